// File: rtl/dmem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_pkg: shared types and helpers for the data-memory port adapter |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } dmem_state_e;

  // funct3[1:0] selects the access size; funct3[2] selects zero-extension
  localparam logic [1:0] c_SIZE_B = 2'd0;
  localparam logic [1:0] c_SIZE_H = 2'd1;
  localparam logic [1:0] c_SIZE_W = 2'd2;
  localparam logic [1:0] c_SIZE_D = 2'd3;
  localparam logic [2:0] c_F3_RSVD = 3'b111;

  function automatic logic [7:0] size_strobe(input logic [1:0] size);
    case (size)
      c_SIZE_B: return 8'h01;
      c_SIZE_H: return 8'h03;
      c_SIZE_W: return 8'h0F;
      default:  return 8'hFF;
    endcase
  endfunction

  function automatic logic size_aligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      c_SIZE_B: return 1'b1;
      c_SIZE_H: return (off[0] == 1'b0);
      c_SIZE_W: return (off[1:0] == 2'b00);
      default:  return (off == 3'b000);
    endcase
  endfunction

  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_lane_align: store lane shift/strobes, load lane select/extend  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [63:0] st_data,
  input  logic [2:0]  st_off,
  input  logic [1:0]  st_size,
  output logic [63:0] st_wdata,
  output logic [7:0]  st_wstrb,
  input  logic [63:0] ld_rdata,
  input  logic [2:0]  ld_off,
  input  logic [2:0]  ld_funct3,
  output logic [63:0] ld_data
);

  logic [63:0] w_shift;
  logic        w_sign;

  assign st_wdata = st_data << {st_off, 3'b000};
  assign st_wstrb = size_strobe(st_size) << st_off;

  always_comb begin
    w_shift = ld_rdata >> {ld_off, 3'b000};
    w_sign  = ~ld_funct3[2];
    ld_data = w_shift;
    case (ld_funct3[1:0])
      c_SIZE_B: ld_data = {{56{w_sign & w_shift[7]}},  w_shift[7:0]};
      c_SIZE_H: ld_data = {{48{w_sign & w_shift[15]}}, w_shift[15:0]};
      c_SIZE_W: ld_data = {{32{w_sign & w_shift[31]}}, w_shift[31:0]};
      default:  ld_data = w_shift;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_interface.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_interface: single-cycle DM_* access to req/gnt/rvalid adapter  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dmem_interface
  import dmem_pkg::*;
#(
  parameter int N       = 64,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         DM_readEnable,
  input  logic         DM_writeEnable,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  input  logic [2:0]   funct3,
  output logic [N-1:0] DM_readData,
  output logic         stall,
  output logic         misalign,
  output logic         bus_err,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [63:0]  mem_wdata,
  output logic [7:0]   mem_wstrb,
  input  logic         mem_gnt,
  input  logic         mem_rvalid,
  input  logic [63:0]  mem_rdata
);

  localparam int                 c_CNT_W    = cnt_width(TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  dmem_state_e        r_state;
  dmem_state_e        w_next_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_we;
  logic [2:0]         r_off;
  logic [2:0]         r_funct3;
  logic [N-1:0]       r_addr;
  logic [63:0]        r_wdata;
  logic [7:0]         r_wstrb;
  logic               r_req;
  logic [N-1:0]       r_read_data;
  logic               r_bus_err;

  logic               w_access;
  logic               w_aligned;
  logic               w_illegal;
  logic               w_timeout;
  logic               w_err_next;
  logic               w_load_rdata;
  logic               w_idle_exit;
  logic [63:0]        w_st_wdata;
  logic [7:0]         w_st_wstrb;
  logic [63:0]        w_ld_data;

  assign w_access  = DM_readEnable | DM_writeEnable;
  assign w_aligned = size_aligned(funct3[1:0], DM_addr[2:0]);
  assign w_illegal = (DM_readEnable & DM_writeEnable)
                   | (DM_readEnable & (funct3 == c_F3_RSVD))
                   | (DM_writeEnable & funct3[2]);
  assign w_timeout = (r_cnt >= c_CNT_LAST);

  assign stall    = w_access & w_aligned & (r_state != ST_DONE);
  assign misalign = w_access & ~w_aligned;

  assign DM_readData = r_read_data;
  assign bus_err     = r_bus_err;
  assign mem_req     = r_req;
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign mem_wstrb   = r_wstrb;

  dmem_lane_align u_lane_align (
    .st_data   (DM_writeData),
    .st_off    (DM_addr[2:0]),
    .st_size   (funct3[1:0]),
    .st_wdata  (w_st_wdata),
    .st_wstrb  (w_st_wstrb),
    .ld_rdata  (mem_rdata),
    .ld_off    (r_off),
    .ld_funct3 (r_funct3),
    .ld_data   (w_ld_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Normal completion wins over a timeout landing in the same cycle
  always_comb begin
    w_next_state = r_state;
    w_err_next   = 1'b0;
    w_load_rdata = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access && w_aligned) begin
          w_next_state = w_illegal ? ST_DONE : ST_REQ;
          w_err_next   = w_illegal;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          w_next_state = r_we ? ST_DONE : ST_WAIT;
        end else if (w_timeout) begin
          w_next_state = ST_DONE;
          w_err_next   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          w_next_state = ST_DONE;
          w_load_rdata = 1'b1;
        end else if (w_timeout) begin
          w_next_state = ST_DONE;
          w_err_next   = 1'b1;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_idle_exit = (r_state == ST_IDLE) && (w_next_state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_off       <= '0;
      r_funct3    <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_req       <= 1'b0;
      r_read_data <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_req     <= (w_next_state == ST_REQ);
      r_bus_err <= w_err_next;

      if (w_idle_exit) begin
        r_cnt    <= '0;
        r_we     <= DM_writeEnable;
        r_off    <= DM_addr[2:0];
        r_funct3 <= funct3;
        r_addr   <= {DM_addr[N-1:3], 3'b000};
        r_wdata  <= w_st_wdata;
        r_wstrb  <= DM_writeEnable ? w_st_wstrb : 8'h00;
      end else if ((r_state == ST_REQ) || (r_state == ST_WAIT)) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // Load data is only presented during DONE; it reads as zero elsewhere
      if (w_load_rdata) begin
        r_read_data <= w_ld_data;
      end else if (w_err_next || (r_state == ST_DONE)) begin
        r_read_data <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_interface.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dmem_interface: scoreboard bench with a memory responder model   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_dmem_interface;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        DM_readEnable, DM_writeEnable;
  logic [63:0] DM_addr, DM_writeData;
  logic [2:0]  funct3;
  logic [63:0] DM_readData;
  logic        stall, misalign, bus_err;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [63:0] mem_rdata;

  dmem_interface #(.N(64), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .DM_readEnable(DM_readEnable), .DM_writeEnable(DM_writeEnable),
    .DM_addr(DM_addr), .DM_writeData(DM_writeData), .funct3(funct3),
    .DM_readData(DM_readData), .stall(stall), .misalign(misalign), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    logic        mis;
    int          stall_cycles;
  } resp_t;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [7:0]  strb;
    logic [63:0] wdata;
  } req_t;

  resp_t resp_q[$];
  req_t  req_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  int          cfg_gnt_delay = 0;
  int          cfg_rv_delay = 1;
  bit          cfg_no_gnt = 0;
  logic [63:0] cfg_rdata = '0;

  task automatic check64(input string what, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", what, act, exp, $time);
    end
  endtask

  // Reference load result: pick the addressed bytes, then extend by funct3
  function automatic logic [63:0] model_load(input logic [2:0] f3, input int off, input logic [63:0] rd);
    int          nbytes;
    logic [63:0] v;
    logic [63:0] mask;
    nbytes = 1 << f3[1:0];
    v = rd >> (8 * off);
    mask = (nbytes == 8) ? '1 : ((64'd1 << (8 * nbytes)) - 64'd1);
    v = v & mask;
    if (!f3[2] && nbytes < 8 && v[8 * nbytes - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic issue(input bit rd, input bit wr, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, input int g, input int rv, input bit nog,
                       input logic [63:0] rdata);
    resp_t       r;
    req_t        q;
    int          nbytes;
    int          off;
    bit          aligned;
    bit          illegal;
    bit          done;
    logic [15:0] m;
    nbytes  = 1 << f3[1:0];
    off     = int'(addr[2:0]);
    aligned = (addr[2:0] & 3'(nbytes - 1)) == 3'd0;
    illegal = (rd && wr) || (rd && f3 == 3'b111) || (wr && f3[2]);
    r.mis = !aligned;
    r.err = 1'b0;
    r.rdata = '0;
    r.stall_cycles = 0;
    if (aligned && illegal) begin
      r.err = 1'b1;
      r.stall_cycles = 1;
    end else if (aligned) begin
      m = (16'd1 << nbytes) - 16'd1;
      q.addr  = addr & ~64'h7;
      q.we    = wr;
      q.strb  = 8'(m << off);
      q.wdata = wdata << (8 * off);
      req_q.push_back(q);
      if (nog) begin
        r.err = 1'b1;
        r.stall_cycles = 1 + TIMEOUT;
      end else if (wr) begin
        r.stall_cycles = 2 + g;
      end else begin
        r.stall_cycles = 2 + g + rv;
        r.rdata = model_load(f3, off, rdata);
      end
    end
    resp_q.push_back(r);
    cfg_gnt_delay = g;
    cfg_rv_delay  = rv;
    cfg_no_gnt    = nog;
    cfg_rdata     = rdata;
    @(posedge clk); #1;
    DM_readEnable  = rd;
    DM_writeEnable = wr;
    funct3         = f3;
    DM_addr        = addr;
    DM_writeData   = wdata;
    done = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      $display("FAIL access_hang: stall still high after 100 cycles, required low");
      $fatal(1, "access did not complete");
    end
    @(posedge clk); #1;
    DM_readEnable  = 1'b0;
    DM_writeEnable = 1'b0;
    DM_addr        = {$urandom(), $urandom()};
    DM_writeData   = {$urandom(), $urandom()};
  endtask

  // Memory model: grants after cfg_gnt_delay cycles of mem_req, read data
  // follows cfg_rv_delay cycles after the grant
  initial begin : responder
    int req_cyc;
    int wait_cyc;
    bit pending;
    req_cyc = 0; wait_cyc = 0; pending = 0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom(), $urandom()};
      if (pending) begin
        wait_cyc++;
        if (wait_cyc == cfg_rv_delay) begin
          mem_rvalid = 1'b1;
          mem_rdata  = cfg_rdata;
          pending    = 0;
        end
      end else if (mem_req) begin
        if (!cfg_no_gnt && req_cyc == cfg_gnt_delay) begin
          mem_gnt = 1'b1;
          req_cyc = 0;
          if (!mem_we) begin
            pending  = 1;
            wait_cyc = 0;
          end
        end else begin
          req_cyc++;
        end
      end else begin
        req_cyc = 0;
      end
    end
  end

  initial begin : resp_monitor
    int    stall_cnt;
    bit    prev_resp;
    resp_t r;
    stall_cnt = 0; prev_resp = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_cnt = 0;
        prev_resp = 0;
        continue;
      end
      if (prev_resp) check64("bus_err_pulse_width", 64'(bus_err), 64'd0);
      prev_resp = 0;
      if (DM_readEnable || DM_writeEnable) begin
        if (stall) begin
          stall_cnt++;
        end else begin
          if (resp_q.size() == 0) begin
            check64("unexpected_response", 64'd1, 64'd0);
          end else begin
            r = resp_q.pop_front();
            check64("DM_readData", DM_readData, r.rdata);
            check64("bus_err", 64'(bus_err), 64'(r.err));
            check64("misalign", 64'(misalign), 64'(r.mis));
            check64("stall_cycles", 64'(stall_cnt), 64'(r.stall_cycles));
            check64("mem_req_at_done", 64'(mem_req), 64'd0);
          end
          stall_cnt = 0;
          prev_resp = 1;
        end
      end
    end
  end

  initial begin : req_monitor
    bit   prev;
    req_t q;
    prev = 0;
    forever begin
      @(negedge clk);
      if (mem_req && !prev) begin
        if (req_q.size() == 0) begin
          check64("unexpected_mem_req", 64'd1, 64'd0);
        end else begin
          q = req_q.pop_front();
          check64("mem_addr", mem_addr, q.addr);
          check64("mem_we", 64'(mem_we), 64'(q.we));
          if (q.we) begin
            check64("mem_wstrb", 64'(mem_wstrb), 64'(q.strb));
            check64("mem_wdata", mem_wdata, q.wdata);
          end
        end
      end
      prev = mem_req;
    end
  end

  initial begin : driver
    int          sel;
    int          nb;
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [2:0]  off;
    logic [63:0] addr;
    req_t        q;
    reset = 1'b0;
    DM_readEnable = 1'b0; DM_writeEnable = 1'b0;
    DM_addr = '0; DM_writeData = '0; funct3 = '0;
    repeat (2) @(negedge clk);
    check64("reset_mem_req", 64'(mem_req), 64'd0);
    check64("reset_mem_we", 64'(mem_we), 64'd0);
    check64("reset_mem_wstrb", 64'(mem_wstrb), 64'd0);
    check64("reset_readData", DM_readData, 64'd0);
    check64("reset_bus_err", 64'(bus_err), 64'd0);
    check64("reset_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    issue(0, 1, 3'b011, 64'h10, 64'h1122334455667788, 0, 1, 0, '0);         // SD
    issue(1, 0, 3'b000, 64'h13, '0, 0, 2, 0, 64'h0000_0000_8000_0000);       // LB
    issue(1, 0, 3'b100, 64'h13, '0, 0, 2, 0, 64'h0000_0000_8000_0000);       // LBU
    issue(0, 1, 3'b001, 64'h15, 64'hBEEF, 0, 1, 0, '0);                      // SH misaligned
    issue(1, 0, 3'b010, 64'h8, '0, 0, 1, 1, '0);                             // LW, no grant
    issue(1, 1, 3'b011, 64'h18, 64'h55, 0, 1, 0, '0);                        // read & write

    // Reset while the load waits for data; the late rvalid must be dropped
    cfg_gnt_delay = 0; cfg_rv_delay = 6; cfg_no_gnt = 0; cfg_rdata = 64'hDEAD_BEEF_0123_4567;
    q.addr = 64'h20; q.we = 1'b0; q.strb = 8'h00; q.wdata = '0;
    req_q.push_back(q);
    @(posedge clk); #1;
    DM_readEnable = 1'b1; funct3 = 3'b011; DM_addr = 64'h20;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b0;
    DM_readEnable = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check64("rst_wait_mem_req", 64'(mem_req), 64'd0);
      check64("rst_wait_readData", DM_readData, 64'd0);
      check64("rst_wait_bus_err", 64'(bus_err), 64'd0);
    end

    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 19);
      rd = (sel == 0) || (sel <= 10);
      wr = (sel == 0) || (sel > 10);
      if (wr && !rd) f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      else f3 = 3'($urandom_range(0, 7));
      nb = 1 << f3[1:0];
      off = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) off = off & ~3'(nb - 1);
      addr = ({$urandom(), $urandom()} & ~64'h7) | 64'(off);
      issue(rd, wr, f3, addr, {$urandom(), $urandom()}, int'($urandom_range(0, 3)),
            int'($urandom_range(1, 3)), ($urandom_range(0, 24) == 0), {$urandom(), $urandom()});
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(negedge clk);
    check64("resp_queue_drained", 64'(resp_q.size()), 64'd0);
    check64("req_queue_drained", 64'(req_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
